// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT stage sequencer and its address generator.
package fft_pkg;

  localparam int MAX_LOG2N = 10;
  localparam int MIN_LOG2N = 3;
  localparam int LW        = $clog2(MAX_LOG2N + 1);
  localparam int JW        = MAX_LOG2N - 1;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, RDOUT, DONE} seq_state_t;

  typedef struct packed {
    logic [MAX_LOG2N-1:0] addr_a;
    logic [MAX_LOG2N-1:0] addr_b;
    logic [JW-1:0]        tw_idx;
    logic [LW-1:0]        stage;
    logic                 inverse;
    logic                 last;
  } bf_cmd_t;

  // Reverses the low l bits of v; bits at or above l come out as zero.
  function automatic logic [MAX_LOG2N-1:0] bit_rev(input logic [MAX_LOG2N-1:0] v,
                                                   input logic [LW-1:0] l);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2N; i++)
      if (i < int'(l)) r[int'(l) - 1 - i] = v[i];
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 DIT butterfly address / twiddle generator for butterfly j of stage s.
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [LW-1:0] stage,
  input  logic [JW-1:0] j,
  input  logic          inverse,
  input  logic          last,
  output bf_cmd_t       cmd
);

  logic [MAX_LOG2N-1:0] span;
  logic [MAX_LOG2N-1:0] pos;
  logic [MAX_LOG2N-1:0] grp;
  logic [MAX_LOG2N-1:0] addr_a;

  // Twiddles are normalised to the N_max/2 table, so deeper stages use a smaller stride.
  always_comb begin
    span        = MAX_LOG2N'(1) << stage;
    pos         = {1'b0, j} & (span - MAX_LOG2N'(1));
    grp         = {1'b0, j} >> stage;
    addr_a      = (grp << (stage + LW'(1))) | pos;
    cmd.addr_a  = addr_a;
    cmd.addr_b  = addr_a | span;
    cmd.tw_idx  = pos[JW-1:0] << (JW - int'(stage));
    cmd.stage   = stage;
    cmd.inverse = inverse;
    cmd.last    = last;
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Frame sequencer for the in-place radix-2 DIT butterfly engine, with drain gaps between stages.
// Define FFT_SEQ_BITREV_EN to add the bit-reversed readout phase after the last stage.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int PIPE_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LW-1:0]        cfg_log2n,
  input  logic                 cfg_inverse,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 bf_valid,
  input  logic                 bf_ready,
  output logic [MAX_LOG2N-1:0] bf_addr_a,
  output logic [MAX_LOG2N-1:0] bf_addr_b,
  output logic [JW-1:0]        bf_tw_idx,
  output logic [LW-1:0]        bf_stage,
  output logic                 bf_inverse,
  output logic                 bf_last_in_stage,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [MAX_LOG2N-1:0] rd_addr,
  output logic                 rd_last
);

  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  seq_state_t     state_q, state_d, after_stage;
  logic [LW-1:0]  log2n_q, s_q;
  logic [JW-1:0]  j_q;
  logic [DW-1:0]  drain_q;
  logic           inv_q, err_q;
  logic           cfg_ok, start_ok, bf_hs, j_last, s_last, drain_end, stage_end;
  bf_cmd_t        cmd;

  assign cfg_ok    = (cfg_log2n >= LW'(MIN_LOG2N)) && (cfg_log2n <= LW'(MAX_LOG2N));
  assign start_ok  = (state_q == IDLE) && start;
  assign bf_hs     = (state_q == ISSUE) && bf_ready;
  assign j_last    = (j_q == JW'((32'd1 << (log2n_q - LW'(1))) - 32'd1));
  assign s_last    = (s_q == log2n_q - LW'(1));
  assign drain_end = (state_q == DRAIN) && (drain_q == DW'(PIPE_DEPTH - 1));
  assign stage_end = (PIPE_DEPTH == 0) ? (bf_hs && j_last) : drain_end;

`ifdef FFT_SEQ_BITREV_EN
  localparam seq_state_t FINAL_ST = RDOUT;
  logic [MAX_LOG2N-1:0] k_q;
  logic                 rd_hs, k_last;

  assign rd_hs  = (state_q == RDOUT) && rd_ready;
  assign k_last = (k_q == MAX_LOG2N'((32'd1 << log2n_q) - 32'd1));

  always_ff @(posedge clk) begin
    if (rst || abort)  k_q <= '0;
    else if (start_ok) k_q <= '0;
    else if (rd_hs)    k_q <= k_q + MAX_LOG2N'(1);
  end

  assign rd_valid = (state_q == RDOUT);
  assign rd_addr  = rd_valid ? bit_rev(k_q, log2n_q) : '0;
  assign rd_last  = rd_valid && k_last;
`else
  localparam seq_state_t FINAL_ST = DONE;
  logic unused_rd_ready;

  assign unused_rd_ready = rd_ready;
  assign rd_valid        = 1'b0;
  assign rd_addr         = '0;
  assign rd_last         = 1'b0;
`endif

  always_comb begin
    after_stage = s_last ? FINAL_ST : ISSUE;
    state_d     = state_q;
    case (state_q)
      IDLE:  if (start && cfg_ok) state_d = ISSUE;
      ISSUE: if (bf_hs && j_last) state_d = (PIPE_DEPTH == 0) ? after_stage : DRAIN;
      DRAIN: if (drain_end) state_d = after_stage;
`ifdef FFT_SEQ_BITREV_EN
      RDOUT: if (rd_hs && k_last) state_d = DONE;
`else
      RDOUT: state_d = IDLE;
`endif
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Abort shares the reset path so it wins over a same-cycle final handshake.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q <= IDLE;
      log2n_q <= '0;
      inv_q   <= 1'b0;
      s_q     <= '0;
      j_q     <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_ok && !cfg_ok;
      if (start_ok && cfg_ok) begin
        log2n_q <= cfg_log2n;
        inv_q   <= cfg_inverse;
        s_q     <= '0;
        j_q     <= '0;
        drain_q <= '0;
      end
      if (bf_hs) j_q <= j_last ? '0 : j_q + JW'(1);
      if (state_q == DRAIN) drain_q <= drain_end ? '0 : drain_q + DW'(1);
      if (stage_end && !s_last) s_q <= s_q + LW'(1);
    end
  end

  fft_addr_gen u_addr_gen (
    .stage   (s_q),
    .j       (j_q),
    .inverse (inv_q),
    .last    (j_last),
    .cmd     (cmd)
  );

  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign err              = err_q;
  assign bf_valid         = (state_q == ISSUE);
  assign bf_addr_a        = bf_valid ? cmd.addr_a : '0;
  assign bf_addr_b        = bf_valid ? cmd.addr_b : '0;
  assign bf_tw_idx        = bf_valid ? cmd.tw_idx : '0;
  assign bf_stage         = bf_valid ? cmd.stage : '0;
  assign bf_inverse       = bf_valid && cmd.inverse;
  assign bf_last_in_stage = bf_valid && cmd.last;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomised self-checking bench for fft_stage_sequencer against a butterfly-list reference model.
module tb_fft_stage_sequencer;

  localparam int PD      = 4;
  localparam int TW_HALF = 512;

  logic       clk, rst, cfg_inverse, start, abort;
  logic [3:0] cfg_log2n, bf_stage;
  logic       busy, done, err, bf_valid, bf_ready, bf_inverse, bf_last_in_stage;
  logic [9:0] bf_addr_a, bf_addr_b, rd_addr;
  logic [8:0] bf_tw_idx;
  logic       rd_valid, rd_ready, rd_last;
  int         total, bad;

  fft_stage_sequencer #(.PIPE_DEPTH(PD)) dut (
    .clk(clk), .rst(rst), .cfg_log2n(cfg_log2n), .cfg_inverse(cfg_inverse),
    .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
    .bf_tw_idx(bf_tw_idx), .bf_stage(bf_stage), .bf_inverse(bf_inverse),
    .bf_last_in_stage(bf_last_in_stage), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr(rd_addr), .rd_last(rd_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {13'b0, busy, done, err, bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage,
            bf_inverse, bf_last_in_stage, rd_valid, rd_addr, rd_last};
  endfunction

  function automatic logic [63:0] bf_vec();
    return {29'b0, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage, bf_inverse, bf_last_in_stage};
  endfunction

  function automatic logic [63:0] bf_word(input int a, input int b, input int tw, input int s,
                                          input bit inv, input bit last);
    return {29'b0, 10'(a), 10'(b), 9'(tw), 4'(s), inv, last};
  endfunction

  task automatic check_idle(input string tag);
    checkOutput(tag, out_vec(), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic err_case(input int l);
    cfg_log2n = 4'(l);
    start     = 1'b1;
    step();
    start = 1'b0;
    checkOutput("err_pulse", 64'(err), 64'd1);
    checkOutput("err_quiet", 64'({busy, bf_valid, done}), 64'd0);
    step();
    check_idle("err_clear");
  endtask

  // mode: 0 full frame, 1 abort in stage-1 drain, 2 abort on final handshake, 3 reset mid-issue
  task automatic applyStimulus(input int l, input bit inv, input int stall_pct, input int mode);
    int n, cyc, hs, gap, last_stage, stall_left, exp_lat;
    bit in_gap, finished, stop, forced;
    logic lst;
    logic [63:0] bf_q[$];
`ifdef FFT_SEQ_BITREV_EN
    logic [63:0] rd_q[$];
`endif
    n = 1 << l;
    for (int s = 0; s < l; s++) begin
      int span;
      span = 1 << s;
      for (int base = 0; base < n; base += 2 * span)
        for (int p = 0; p < span; p++)
          bf_q.push_back(bf_word(base + p, base + p + span, p * (TW_HALF / span), s, inv,
                                 (base + 2 * span == n) && (p == span - 1)));
    end
    exp_lat = l * (n / 2 + PD) + 1;
`ifdef FFT_SEQ_BITREV_EN
    for (int k = 0; k < n; k++) begin
      int r;
      r = 0;
      for (int i = 0; i < l; i++) r = r * 2 + ((k >> i) & 1);
      rd_q.push_back(64'({10'(r), k == n - 1}));
    end
    exp_lat += n;
`endif

    cfg_log2n   = 4'(l);
    cfg_inverse = inv;
    start       = 1'b1;
    step();
    cyc = 1; hs = 0; gap = 0; last_stage = -1; stall_left = 0;
    in_gap = 0; finished = 0; stop = 0; forced = 0;

    while (!finished && !stop && cyc < 20000) begin
      start = 1'b0;
      if (!done) begin
        start       = 1'($urandom_range(1));
        cfg_log2n   = 4'($urandom_range(15));
        cfg_inverse = 1'($urandom_range(1));
      end
      bf_ready = ($urandom_range(99) >= stall_pct);
      rd_ready = ($urandom_range(99) >= stall_pct);
      if (stall_left > 0) begin
        bf_ready = 1'b0;
        stall_left--;
      end
      checkOutput("busy_err", 64'({busy, err}), 64'd2);
`ifndef FFT_SEQ_BITREV_EN
      checkOutput("rd_tied", 64'({rd_valid, rd_addr, rd_last}), 64'd0);
`endif
      if (done) begin
        if (in_gap) checkOutput("drain_gap", 64'(gap), 64'(PD));
        checkOutput("handshakes", 64'(hs), 64'(l * n / 2));
        checkOutput("bf_left", 64'(bf_q.size()), 64'd0);
`ifdef FFT_SEQ_BITREV_EN
        checkOutput("rd_left", 64'(rd_q.size()), 64'd0);
`endif
        if (stall_pct == 0) checkOutput("latency", 64'(cyc), 64'(exp_lat));
        finished = 1;
      end else if (bf_valid) begin
        if (in_gap) begin
          checkOutput("drain_gap", 64'(gap), 64'(PD));
          in_gap = 0;
        end
        if (mode == 3 && hs == 5) begin
          rst       = 1'b1;
          start     = 1'b1;
          cfg_log2n = 4'd4;
          stop      = 1;
        end else begin
          if (stall_pct > 0 && !forced && hs == n / 4) begin
            bf_ready   = 1'b0;
            stall_left = 2;
            forced     = 1;
          end
          if (mode == 2 && bf_q.size() == 1) begin
            bf_ready = 1'b1;
            abort    = 1'b1;
            start    = 1'b0;
            stop     = 1;
          end
          checkOutput("bf_expected", 64'(bf_q.size() > 0), 64'd1);
          if (bf_q.size() > 0) begin
            checkOutput("bf_cmd", bf_vec(), bf_q[0]);
            if (bf_ready) begin
              lst        = bf_q[0][0];
              last_stage = int'(bf_stage);
              void'(bf_q.pop_front());
              hs++;
              if (lst) begin
                in_gap = 1;
                gap    = 0;
              end
            end
          end
        end
`ifdef FFT_SEQ_BITREV_EN
      end else if (rd_valid) begin
        if (in_gap) begin
          checkOutput("drain_gap", 64'(gap), 64'(PD));
          in_gap = 0;
        end
        checkOutput("rd_expected", 64'(rd_q.size() > 0), 64'd1);
        if (rd_q.size() > 0) begin
          checkOutput("rd_cmd", 64'({rd_addr, rd_last}), rd_q[0]);
          if (rd_ready) void'(rd_q.pop_front());
        end
`endif
      end else begin
        checkOutput("valid_gap", 64'(in_gap), 64'd1);
        if (in_gap) gap++;
        if (mode == 1 && in_gap && last_stage == 1 && gap == 1) begin
          abort = 1'b1;
          start = 1'b0;
          stop  = 1;
        end
      end
      step();
      cyc++;
    end

    if (stop && mode == 3) begin
      check_idle("rst_hold");
      step();
      check_idle("rst_hold2");
      rst   = 1'b0;
      start = 1'b0;
      step();
      check_idle("rst_release");
    end else if (stop) begin
      abort = 1'b0;
      start = 1'b0;
      check_idle("abort_idle");
      step();
      check_idle("abort_after");
    end else begin
      start = 1'b0;
      checkOutput("frame_finished", 64'(finished), 64'd1);
      checkOutput("done_pulse", 64'({busy, done}), 64'd0);
      if (!finished) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; abort = 1'b0; start = 1'b0; cfg_log2n = '0; cfg_inverse = 1'b0;
    bf_ready = 1'b0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    start = 1'b1;
    cfg_log2n = 4'd3;
    step();
    check_idle("start_in_reset");
    rst   = 1'b0;
    start = 1'b0;
    step();
    check_idle("post_reset");

    applyStimulus(3, 1'b0, 0, 0);
    applyStimulus(10, 1'b1, 30, 0);
    err_case(2);
    err_case(11);
    applyStimulus(5, 1'b0, 20, 1);
    applyStimulus(4, 1'b1, 20, 2);
    applyStimulus(4, 1'b0, 0, 0);
    applyStimulus(6, 1'b1, 0, 3);
    applyStimulus(3, 1'b1, 40, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus($urandom_range(3, 7), 1'($urandom_range(1)), $urandom_range(0, 1) * 35, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
